// File: rtl/udp_frame_tx_if.sv
// AXI-Stream byte channel from the UDP frame packager to the MAC.
interface udp_frame_tx_if;
    logic [7:0] MAC_DATA_OUT;
    logic       MAC_DATA_READY;
    logic       MAC_DATA_VALID;
    logic       MAC_DATA_LAST;
    logic       MAC_DATA_TUSER;

    modport master (
        output MAC_DATA_OUT,
        output MAC_DATA_VALID,
        output MAC_DATA_LAST,
        output MAC_DATA_TUSER,
        input  MAC_DATA_READY
    );

    modport slave (
        input  MAC_DATA_OUT,
        input  MAC_DATA_VALID,
        input  MAC_DATA_LAST,
        input  MAC_DATA_TUSER,
        output MAC_DATA_READY
    );
endinterface

// File: rtl/udp_frame_tx.sv
// IPv4/UDP transmit packager: captures one message plus addressing, computes the
// IPv4 header checksum over 10 cycles, then streams ETH+IP+UDP+payload over AXI-S.
module udp_frame_tx #(
    parameter int unsigned MSG_WIDTH     = 10,
    parameter int unsigned PAYLOAD_BYTES = 18,
    parameter logic [7:0]  IP_TTL        = 8'h80
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [31:0]          ACCELERATOR_IP_ADDRESS,
    input  logic [47:0]          ACCELERATOR_MAC_ADDRESS,
    input  logic [15:0]          ACCELERATOR_UDP_PORT,
    input  logic [31:0]          RECIPIENT_IP_ADDRESS,
    input  logic [47:0]          RECIPIENT_MAC_ADDRESS,
    input  logic [15:0]          RECIPIENT_UDP_PORT,
    input  logic [MSG_WIDTH-1:0] RECIPIENT_MESSAGE,
    input  logic                 START_IP_TXN,
    output logic                 READY_FOR_SEND,
    udp_frame_tx_if.master       mac
);

    localparam int unsigned MSG_BYTES = (MSG_WIDTH + 7) / 8;
    localparam int unsigned PW        = 8 * PAYLOAD_BYTES;
    localparam logic [15:0] IP_LEN    = 16'(28 + PAYLOAD_BYTES);
    localparam logic [15:0] UDP_LEN   = 16'(8 + PAYLOAD_BYTES);
    localparam logic [7:0]  LAST_CNT  = 8'(PAYLOAD_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE, CSUM, SEND_ETH, SEND_IP, SEND_UDP, SEND_DATA
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [19:0]          acc_q, acc_d;
    logic [15:0]          csum_q, csum_d;
    logic [15:0]          ip_id_q, ip_id_d;
    logic [31:0]          src_ip_q, src_ip_d, dst_ip_q, dst_ip_d;
    logic [47:0]          src_mac_q, src_mac_d, dst_mac_q, dst_mac_d;
    logic [15:0]          src_port_q, src_port_d, dst_port_q, dst_port_d;
    logic [MSG_WIDTH-1:0] msg_q, msg_d;
    logic                 rfs_q, rfs_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic [7:0]           data_q, data_d;

    state_e               nxt_state;
    logic [7:0]           nxt_cnt;
    logic [7:0]           nxt_byte;
    logic                 nxt_last;
    logic [7:0]           hdr_idx;
    logic [335:0]         hdr, hdr_sh;
    logic [PW-1:0]        pay, pay_sh;
    logic [15:0]          hw;
    logic [19:0]          fold1;
    logic [15:0]          fold2;

    // Header bytes 0..41 in wire order, byte 0 in the top bits.
    always_comb begin
        hdr = {dst_mac_q, src_mac_q, 16'h0800,
               16'h4500, IP_LEN, ip_id_q, 16'h0000, IP_TTL, 8'h11, csum_q,
               src_ip_q, dst_ip_q,
               src_port_q, dst_port_q, UDP_LEN, 16'h0000};
        pay = PW'(msg_q) << (PW - 8 * MSG_BYTES);
    end

    always_comb begin
        unique case (cnt_q)
            8'd0:    hw = 16'h4500;
            8'd1:    hw = IP_LEN;
            8'd2:    hw = ip_id_q;
            8'd3:    hw = 16'h0000;
            8'd4:    hw = {IP_TTL, 8'h11};
            8'd5:    hw = src_ip_q[31:16];
            8'd6:    hw = src_ip_q[15:0];
            8'd7:    hw = dst_ip_q[31:16];
            8'd8:    hw = dst_ip_q[15:0];
            default: hw = 16'h0000;
        endcase
    end

    // Position and byte of the beat that follows the current one; loaded into the
    // output registers only on a handshake so DATA/LAST hold during a stall.
    always_comb begin
        nxt_state = state_q;
        nxt_cnt   = cnt_q + 8'd1;
        unique case (state_q)
            CSUM: begin
                nxt_state = SEND_ETH;
                nxt_cnt   = '0;
            end
            SEND_ETH: if (cnt_q == 8'd13) begin
                nxt_state = SEND_IP;
                nxt_cnt   = '0;
            end
            SEND_IP: if (cnt_q == 8'd19) begin
                nxt_state = SEND_UDP;
                nxt_cnt   = '0;
            end
            SEND_UDP: if (cnt_q == 8'd7) begin
                nxt_state = SEND_DATA;
                nxt_cnt   = '0;
            end
            SEND_DATA: if (cnt_q == LAST_CNT) begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
            end
            default: nxt_cnt = '0;
        endcase

        unique case (nxt_state)
            SEND_IP:  hdr_idx = 8'd14 + nxt_cnt;
            SEND_UDP: hdr_idx = 8'd34 + nxt_cnt;
            default:  hdr_idx = nxt_cnt;
        endcase
        hdr_sh = hdr << {hdr_idx, 3'b000};
        pay_sh = pay << {nxt_cnt, 3'b000};

        unique case (nxt_state)
            SEND_ETH, SEND_IP, SEND_UDP: nxt_byte = hdr_sh[335:328];
            SEND_DATA:                   nxt_byte = pay_sh[PW-1 -: 8];
            default:                     nxt_byte = '0;
        endcase
        nxt_last = (nxt_state == SEND_DATA) && (nxt_cnt == LAST_CNT);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        csum_d     = csum_q;
        ip_id_d    = ip_id_q;
        src_ip_d   = src_ip_q;
        dst_ip_d   = dst_ip_q;
        src_mac_d  = src_mac_q;
        dst_mac_d  = dst_mac_q;
        src_port_d = src_port_q;
        dst_port_d = dst_port_q;
        msg_d      = msg_q;
        valid_d    = valid_q;
        last_d     = last_q;
        data_d     = data_q;
        fold1      = {4'h0, acc_q[15:0]} + {16'h0000, acc_q[19:16]};
        fold2      = fold1[15:0] + {12'h000, fold1[19:16]};

        unique case (state_q)
            IDLE: begin
                if (START_IP_TXN && rfs_q) begin
                    src_ip_d   = ACCELERATOR_IP_ADDRESS;
                    dst_ip_d   = RECIPIENT_IP_ADDRESS;
                    src_mac_d  = ACCELERATOR_MAC_ADDRESS;
                    dst_mac_d  = RECIPIENT_MAC_ADDRESS;
                    src_port_d = ACCELERATOR_UDP_PORT;
                    dst_port_d = RECIPIENT_UDP_PORT;
                    msg_d      = RECIPIENT_MESSAGE;
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = CSUM;
                end
            end
            CSUM: begin
                if (cnt_q == 8'd9) begin
                    csum_d  = ~fold2;
                    state_d = nxt_state;
                    cnt_d   = nxt_cnt;
                    valid_d = 1'b1;
                    data_d  = nxt_byte;
                    last_d  = nxt_last;
                end else begin
                    acc_d = acc_q + {4'h0, hw};
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                if (valid_q && mac.MAC_DATA_READY) begin
                    state_d = nxt_state;
                    cnt_d   = nxt_cnt;
                    data_d  = nxt_byte;
                    last_d  = nxt_last;
                    if (nxt_state == IDLE) begin
                        valid_d = 1'b0;
                        ip_id_d = ip_id_q + 16'd1;
                    end
                end
            end
        endcase

        rfs_d = (state_d == IDLE);
    end

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            csum_q     <= '0;
            ip_id_q    <= '0;
            src_ip_q   <= '0;
            dst_ip_q   <= '0;
            src_mac_q  <= '0;
            dst_mac_q  <= '0;
            src_port_q <= '0;
            dst_port_q <= '0;
            msg_q      <= '0;
            rfs_q      <= 1'b1;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            csum_q     <= csum_d;
            ip_id_q    <= ip_id_d;
            src_ip_q   <= src_ip_d;
            dst_ip_q   <= dst_ip_d;
            src_mac_q  <= src_mac_d;
            dst_mac_q  <= dst_mac_d;
            src_port_q <= src_port_d;
            dst_port_q <= dst_port_d;
            msg_q      <= msg_d;
            rfs_q      <= rfs_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            data_q     <= data_d;
        end
    end

    assign READY_FOR_SEND     = rfs_q;
    assign mac.MAC_DATA_OUT   = data_q;
    assign mac.MAC_DATA_VALID = valid_q;
    assign mac.MAC_DATA_LAST  = last_q;
    assign mac.MAC_DATA_TUSER = 1'b0;

endmodule
